pc_ctrl: RTL

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl_pkg.sv | 17 +
 rtl/pc_ctrl_jump_cond.sv | 13 +
 rtl/pc_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and jump-field constants for the program-counter controller.
package pc_ctrl_pkg;

  localparam int unsigned JBITS_W = 3;
  localparam int unsigned JGT     = 0;
  localparam int unsigned JEQ     = 1;
  localparam int unsigned JLT     = 2;
  localparam logic [JBITS_W-1:0] JMP = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/pc_ctrl_jump_cond.sv
// Combinational jump-condition evaluation from the three jump bits and ALU flags.
module jump_cond
  import pc_ctrl_pkg::*;
(
  input  logic [JBITS_W-1:0] jbits,
  input  logic               zr,
  input  logic               ng,
  output logic               taken
);

  assign taken = (jbits[JLT] & ng) | (jbits[JEQ] & zr) | (jbits[JGT] & ~ng & ~zr);

endmodule

// File: rtl/pc_ctrl.sv
// Fetch/execute sequencer: requests instructions, strobes the PC and detects the halt idiom.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_data,
  input  logic [WIDTH-1:0] pc_value,
  input  logic [WIDTH-1:0] a_value,
  input  logic             alu_zr,
  input  logic             alu_ng,
  output logic             pc_load,
  output logic             pc_inc,
  output logic [WIDTH-1:0] pc_target,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  output logic             halted,
  output logic [WIDTH-1:0] retired
);

  state_t state;
  state_t state_nxt;
  logic   is_compute;
  logic   cond_taken;
  logic   jump;
  logic   halt_now;

  // The top instruction bit marks a compute instruction; only those may jump.
  assign is_compute = instr[WIDTH-1];

  jump_cond u_jump_cond (
    .jbits (instr[JBITS_W-1:0]),
    .zr    (alu_zr),
    .ng    (alu_ng),
    .taken (cond_taken)
  );

  assign jump      = is_compute & cond_taken;
  assign halt_now  = is_compute && (instr[JBITS_W-1:0] == JMP) && (a_value == pc_value);
  assign pc_target = a_value;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = FETCH;
      FETCH:   if (imem_ack) state_nxt = EXEC;
      EXEC: begin
        if (halt_now) state_nxt = HALT;
        else if (run) state_nxt = FETCH;
        else          state_nxt = IDLE;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    halted      = 1'b0;
    case (state)
      FETCH: imem_req = 1'b1;
      EXEC: begin
        instr_valid = 1'b1;
        pc_load     = jump & ~halt_now;
        pc_inc      = ~jump & ~halt_now;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  // Instruction latch and retired-instruction counter (wraps naturally).
  always_ff @(posedge clk) begin
    if (reset) begin
      instr   <= '0;
      retired <= '0;
    end else begin
      if (state == FETCH && imem_ack) instr <= imem_data;
      if (state == EXEC) retired <= retired + WIDTH'(1);
    end
  end

endmodule
